// File: rtl/object_line_scanner.sv
// Per-scanline object scanner: gathers objects crossing the next line during h-blank
// and reports per-pixel hits. Optional overflow statistics via OBJSCAN_OVERFLOW_STAT_EN.
module object_line_scanner #(
  parameter int MAX_BULLETS = 8,
  parameter int MAX_SLOTS   = 4,
  parameter int TANK_SIZE   = 32,
  parameter int BULLET_SIZE = 8,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [2:0]  tank_addr,
  input  logic [2:0]  oppo_addr,
  input  logic [31:0] tank_data,
  input  logic [31:0] oppo_data,
  input  logic [2:0]  bullet_addr [2*MAX_BULLETS],
  input  logic [31:0] bullet_data [2*MAX_BULLETS],
  output logic        obj_hit,
  output logic [4:0]  obj_id,
  output logic [2:0]  sprite_addr,
  output logic [1:0]  sprite_dir,
  output logic [4:0]  sprite_row,
  output logic [4:0]  sprite_col,
  output logic        line_overflow
`ifdef OBJSCAN_OVERFLOW_STAT_EN
  ,
  output logic [7:0]  overflow_count
`endif
);

  localparam int NUM_OBJ = 2 + 2*MAX_BULLETS;
  localparam int CW      = $clog2(MAX_SLOTS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [4:0] row;
    logic [2:0] addr;
    logic [1:0] dir;
    logic [4:0] id;
  } slot_t;

  state_t        state;
  logic [9:0]    ny;
  logic [4:0]    idx;
  slot_t         back_slot  [MAX_SLOTS];
  slot_t         front_slot [MAX_SLOTS];
  logic [CW-1:0] back_cnt;
  logic [CW-1:0] front_cnt;
  logic          back_ovf;

  function automatic logic [10:0] obj_size(input logic [4:0] id);
    return (id < 5'd2) ? 11'(TANK_SIZE) : 11'(BULLET_SIZE);
  endfunction

  // Object-state mux for the word under inspection this SCAN cycle
  logic [31:0] cur_word;
  logic [2:0]  cur_addr;
  always_comb begin
    cur_word = '0;
    cur_addr = '0;
    if (idx == 5'd0) begin
      cur_word = tank_data;
      cur_addr = tank_addr;
    end else if (idx == 5'd1) begin
      cur_word = oppo_data;
      cur_addr = oppo_addr;
    end else begin
      for (int unsigned b = 0; b < 2*MAX_BULLETS; b++) begin
        if (idx == 5'(b + 2)) begin
          cur_word = bullet_data[b];
          cur_addr = bullet_addr[b];
        end
      end
    end
  end

  logic        unused_word_bits;
  logic [10:0] obj_y;
  logic [10:0] ny_ext;
  logic        keep;
  slot_t       new_slot;
  assign unused_word_bits = ^cur_word[8:0];
  assign obj_y    = {1'b0, cur_word[18:9]};
  assign ny_ext   = {1'b0, ny};
  assign keep     = cur_word[31] && (obj_y <= ny_ext) && (ny_ext < obj_y + obj_size(idx));
  assign new_slot = '{x: cur_word[28:19], row: 5'(ny - cur_word[18:9]),
                      addr: cur_addr, dir: cur_word[30:29], id: idx};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ny            <= '0;
      idx           <= '0;
      back_cnt      <= '0;
      front_cnt     <= '0;
      back_ovf      <= 1'b0;
      line_overflow <= 1'b0;
      for (int unsigned s = 0; s < MAX_SLOTS; s++) begin
        back_slot[s]  <= '0;
        front_slot[s] <= '0;
      end
`ifdef OBJSCAN_OVERFLOW_STAT_EN
      overflow_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pixel_x == 10'(H_ACTIVE)) begin
            ny       <= (pixel_y == 10'(V_ACTIVE - 1)) ? '0 : pixel_y + 10'd1;
            back_cnt <= '0;
            back_ovf <= 1'b0;
            idx      <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (keep) begin
            if (back_cnt < CW'(MAX_SLOTS)) begin
              for (int unsigned s = 0; s < MAX_SLOTS; s++)
                if (back_cnt == CW'(s)) back_slot[s] <= new_slot;
              back_cnt <= back_cnt + 1'b1;
            end else begin
              back_ovf <= 1'b1;
            end
          end
          if (idx == 5'(NUM_OBJ - 1)) state <= DONE;
          else                        idx   <= idx + 5'd1;
        end
        DONE: begin
          if (pixel_x == 10'(H_TOTAL - 1)) begin
            front_slot    <= back_slot;
            front_cnt     <= back_cnt;
            line_overflow <= back_ovf;
`ifdef OBJSCAN_OVERFLOW_STAT_EN
            if (back_ovf && overflow_count != 8'hFF) overflow_count <= overflow_count + 8'd1;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ascending search with a found flag so the lowest slot (lowest object index) wins
  logic       found;
  slot_t      hit_slot;
  logic [4:0] hit_col;
  always_comb begin
    found    = 1'b0;
    hit_slot = '0;
    hit_col  = '0;
    for (int unsigned s = 0; s < MAX_SLOTS; s++) begin
      if (!found && (CW'(s) < front_cnt) &&
          ({1'b0, front_slot[s].x} <= {1'b0, pixel_x}) &&
          ({1'b0, pixel_x} < {1'b0, front_slot[s].x} + obj_size(front_slot[s].id))) begin
        found    = 1'b1;
        hit_slot = front_slot[s];
        hit_col  = 5'(pixel_x - front_slot[s].x);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      obj_hit     <= 1'b0;
      obj_id      <= '0;
      sprite_addr <= '0;
      sprite_dir  <= '0;
      sprite_row  <= '0;
      sprite_col  <= '0;
    end else if (video_on && found) begin
      obj_hit     <= 1'b1;
      obj_id      <= hit_slot.id;
      sprite_addr <= hit_slot.addr;
      sprite_dir  <= hit_slot.dir;
      sprite_row  <= hit_slot.row;
      sprite_col  <= hit_col;
    end else begin
      obj_hit     <= 1'b0;
      obj_id      <= '0;
      sprite_addr <= '0;
      sprite_dir  <= '0;
      sprite_row  <= '0;
      sprite_col  <= '0;
    end
  end

endmodule

// File: tb/tb_object_line_scanner.sv
// Directed bench for object_line_scanner: drives raster lines directly and checks hit payloads.
module tb_object_line_scanner;

  localparam int NB = 16;
  localparam int M_NONE = 0, M_TANK = 1, M_PRIO = 2, M_OVF = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic [2:0]  tank_addr, oppo_addr;
  logic [31:0] tank_data, oppo_data;
  logic [2:0]  bullet_addr [NB];
  logic [31:0] bullet_data [NB];
  logic        obj_hit;
  logic [4:0]  obj_id;
  logic [2:0]  sprite_addr;
  logic [1:0]  sprite_dir;
  logic [4:0]  sprite_row, sprite_col;
  logic        line_overflow;
`ifdef OBJSCAN_OVERFLOW_STAT_EN
  logic [7:0]  overflow_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  object_line_scanner dut (
    .clk(clk), .reset(reset), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .tank_addr(tank_addr), .oppo_addr(oppo_addr),
    .tank_data(tank_data), .oppo_data(oppo_data),
    .bullet_addr(bullet_addr), .bullet_data(bullet_data),
    .obj_hit(obj_hit), .obj_id(obj_id), .sprite_addr(sprite_addr),
    .sprite_dir(sprite_dir), .sprite_row(sprite_row), .sprite_col(sprite_col),
    .line_overflow(line_overflow)
`ifdef OBJSCAN_OVERFLOW_STAT_EN
    , .overflow_count(overflow_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] word(input logic act, input logic [1:0] dir, input int x, input int y);
    return {act, dir, 10'(x), 10'(y), 9'h1A5};
  endfunction

  // Hand-derived expectation per scenario: {hit, id, addr, dir, row, col}
  function automatic logic [20:0] exp_pix(input int mode, input int oy, input int y, input int x,
                                          input logic vid);
    logic [20:0] r;
    r = '0;
    if (!vid) return '0;
    case (mode)
      M_TANK, M_PRIO: begin
        if (y >= oy && y < oy + 32 && x >= 100 && x < 132)
          r = {1'b1, 5'd0, 3'd5, 2'd2, 5'(y - oy), 5'(x - 100)};
        else if (mode == M_PRIO && y == 60 && x >= 300 && x < 308)
          r = {1'b1, 5'd3, 3'd1, 2'd1, 5'd0, 5'(x - 300)};
      end
      M_OVF: begin
        for (int k = 0; k < 4; k++)
          if (y >= oy && y < oy + 8 && x >= 20*k && x < 20*k + 8)
            r = {1'b1, 5'(2 + k), 3'(k), 2'(k), 5'(y - oy), 5'(x - 20*k)};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic run_line(input int y, input int x0, input int x1, input int mode, input int oy,
                          input bit chk, input bit ven);
    logic vid;
    for (int x = x0; x <= x1; x++) begin
      vid      = ven && (x < 640) && (y < 480);
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      video_on = vid;
      @(posedge clk);
      #1;
      if (chk && x < 660)
        check($sformatf("pix y%0d x%0d", y, x),
              32'({obj_hit, obj_id, sprite_addr, sprite_dir, sprite_row, sprite_col}),
              32'(exp_pix(mode, oy, y, x, vid)));
      if (chk && x == 0)
        check($sformatf("ovf y%0d", y), 32'(line_overflow),
              32'(mode == M_OVF && y >= oy && y < oy + 8));
    end
  endtask

  task automatic clear_objs();
    tank_data = '0; oppo_data = '0; tank_addr = '0; oppo_addr = '0;
    for (int b = 0; b < NB; b++) begin
      bullet_data[b] = '0;
      bullet_addr[b] = '0;
    end
  endtask

  task automatic set_five_bullets(input int oy);
    clear_objs();
    for (int b = 0; b < 5; b++) begin
      bullet_data[b] = word(1'b1, 2'(b), 20*b, oy);
      bullet_addr[b] = 3'(b);
    end
  endtask

  initial begin
    reset = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    clear_objs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_payload", 32'({obj_hit, obj_id, sprite_addr, sprite_dir, sprite_row, sprite_col}), 32'd0);
    check("rst_ovf", 32'(line_overflow), 32'd0);
`ifdef OBJSCAN_OVERFLOW_STAT_EN
    check("rst_cnt", 32'(overflow_count), 32'd0);
`endif
    reset = 1'b1;

    // Single tank at (100,50)
    tank_data = word(1'b1, 2'd2, 100, 50);
    tank_addr = 3'd5;
    run_line(48, 0, 799, M_TANK, 50, 0, 1);
    for (int y = 49; y <= 51; y++) run_line(y, 0, 799, M_TANK, 50, 1, 1);
    run_line(80, 0, 799, M_TANK, 50, 0, 1);
    run_line(81, 0, 799, M_TANK, 50, 1, 1);
    run_line(82, 0, 799, M_TANK, 50, 1, 1);

    // Tank priority over bullet 0; bullet 1 visible on its own
    bullet_data[0] = word(1'b1, 2'd3, 120, 60);
    bullet_addr[0] = 3'd3;
    bullet_data[1] = word(1'b1, 2'd1, 300, 60);
    bullet_addr[1] = 3'd1;
    run_line(59, 0, 799, M_PRIO, 50, 0, 1);
    run_line(60, 0, 799, M_PRIO, 50, 1, 1);

    // Five bullets on one line, only four slots
    set_five_bullets(200);
    run_line(199, 0, 799, M_OVF, 200, 0, 1);
    for (int y = 200; y <= 208; y++) run_line(y, 0, 799, M_OVF, 200, 1, 1);
`ifdef OBJSCAN_OVERFLOW_STAT_EN
    check("cnt_after_ovf", 32'(overflow_count), 32'd8);
`endif

    // Inactive word
    clear_objs();
    tank_data = word(1'b0, 2'd2, 10, 10);
    tank_addr = 3'd5;
    run_line(9, 0, 799, M_NONE, 0, 0, 1);
    run_line(10, 0, 799, M_NONE, 0, 1, 1);
    run_line(11, 0, 799, M_NONE, 0, 1, 1);

    // Reset asserted during SCAN on line 100
    set_five_bullets(100);
    run_line(99, 0, 799, M_OVF, 100, 0, 1);
`ifdef OBJSCAN_OVERFLOW_STAT_EN
    check("cnt_pre_rst", 32'(overflow_count), 32'd9);
`endif
    run_line(100, 0, 645, M_OVF, 100, 1, 1);
    check("ovf_pre_rst", 32'(line_overflow), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_payload", 32'({obj_hit, obj_id, sprite_addr, sprite_dir, sprite_row, sprite_col}), 32'd0);
    check("rst_mid_ovf", 32'(line_overflow), 32'd0);
`ifdef OBJSCAN_OVERFLOW_STAT_EN
    check("rst_mid_cnt", 32'(overflow_count), 32'd0);
`endif
    run_line(100, 646, 649, M_NONE, 0, 0, 1);
    reset = 1'b1;
    run_line(100, 650, 799, M_NONE, 0, 1, 1);
    run_line(101, 0, 799, M_NONE, 0, 1, 1);
`ifdef OBJSCAN_OVERFLOW_STAT_EN
    check("cnt_post_rst", 32'(overflow_count), 32'd1);
`endif
    run_line(102, 0, 799, M_OVF, 100, 1, 1);

    // video_on low suppresses hits; scan/swap continue
    clear_objs();
    tank_data = word(1'b1, 2'd2, 100, 300);
    tank_addr = 3'd5;
    run_line(299, 0, 799, M_TANK, 300, 0, 1);
    run_line(300, 0, 799, M_TANK, 300, 1, 0);
    run_line(301, 0, 799, M_TANK, 300, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
